regfile_access_arbiter: RTL and testbench

//   Shares one single-port register file between two requesters (req0, req1).

---
 rtl/regfile_access_arbiter.sv | 160 ++++++++++++++++
 tb/tb_regfile_access_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter giving two requesters shared access to one single-port
// register file; one transaction every three cycles (IDLE -> ACCESS -> DONE).
module regfile_access_arbiter #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic                     req0_we,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    output logic                     req0_ready,
    output logic                     req0_rvalid,
    output logic [DATA_WIDTH-1:0]    req0_rdata,
    input  logic                     req1_valid,
    input  logic                     req1_we,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    output logic                     req1_ready,
    output logic                     req1_rvalid,
    output logic [DATA_WIDTH-1:0]    req1_rdata,
    output logic                     rf_we,
    output logic [ADDRESS_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    input  logic [DATA_WIDTH-1:0]    rf_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_last_grant;
    logic                     r_cmd_we;
    logic [ADDRESS_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0]    r_cmd_wdata;
    logic                     r_cmd_id;
    logic [DATA_WIDTH-1:0]    r_rdata;

    logic                     w_any_valid;
    logic                     w_grant_id;
    logic                     w_sel_we;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_wdata;

    // Winner selection: on a tie the requester not served last goes first.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end else begin
            w_grant_id = 1'b0;
        end
    end

    // Command fields of the winning requester.
    always_comb begin
        if (w_grant_id) begin
            w_sel_we    = req1_we;
            w_sel_addr  = req1_addr;
            w_sel_wdata = req1_wdata;
        end else begin
            w_sel_we    = req0_we;
            w_sel_addr  = req0_addr;
            w_sel_wdata = req0_wdata;
        end
    end

    // Next-state and handshake/register-file outputs; reset silences everything.
    always_comb begin
        w_next_state = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        req0_rvalid  = 1'b0;
        req1_rvalid  = 1'b0;
        rf_we        = 1'b0;
        rf_addr      = '0;
        rf_wdata     = '0;
        if (rst) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        w_next_state = S_ACCESS;
                        req0_ready   = ~w_grant_id;
                        req1_ready   = w_grant_id;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_ACCESS: begin
                    rf_we        = r_cmd_we;
                    rf_addr      = r_cmd_addr;
                    rf_wdata     = r_cmd_wdata;
                    w_next_state = S_DONE;
                end
                S_DONE: begin
                    req0_rvalid  = ~r_cmd_id;
                    req1_rvalid  = r_cmd_id;
                    w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    assign req0_rdata = r_rdata;
    assign req1_rdata = r_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command capture, read-data capture and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_cmd_we     <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wdata  <= '0;
            r_cmd_id     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_cmd_we    <= w_sel_we;
                        r_cmd_addr  <= w_sel_addr;
                        r_cmd_wdata <= w_sel_wdata;
                        r_cmd_id    <= w_grant_id;
                    end
                end
                S_ACCESS: begin
                    r_rdata <= r_cmd_we ? r_cmd_wdata : rf_rdata;
                end
                S_DONE: begin
                    r_last_grant <= r_cmd_id;
                end
                default: begin
                    r_last_grant <= r_last_grant;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Randomized + directed bench: a reference model predicts grants, register
// file activity and completions; a negedge monitor compares against a scoreboard.
module tb_regfile_access_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    vld = 2'b00;
    logic [1:0]    we_a = 2'b00;
    logic [AW-1:0] addr_a [2];
    logic [DW-1:0] wdata_a [2];
    logic          req0_ready, req0_rvalid, req1_ready, req1_rvalid;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;
    logic [DW-1:0] rf_mem [16];

    op_t  pend0[$];
    op_t  pend1[$];
    exp_t sb[$];
    logic [1:0] acc = 2'b00;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    // Reference model state.
    logic [DW-1:0] m_mem [16];
    int   m_last = 1;
    int   m_next_ok = 0;
    int   m_acc_cyc = -1;
    op_t  m_acc;

    regfile_access_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(vld[0]), .req0_we(we_a[0]), .req0_addr(addr_a[0]), .req0_wdata(wdata_a[0]),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(vld[1]), .req1_we(we_a[1]), .req1_addr(addr_a[1]), .req1_wdata(wdata_a[1]),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file the arbiter fronts.
    assign rf_rdata = rf_mem[rf_addr];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_addr] <= rf_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Driver: present the head of each requester's queue, retire it once accepted.
    initial begin
        addr_a[0] = '0; addr_a[1] = '0; wdata_a[0] = '0; wdata_a[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (acc[0]) begin void'(pend0.pop_front()); acc[0] = 1'b0; end
            if (acc[1]) begin void'(pend1.pop_front()); acc[1] = 1'b0; end
            vld[0] = (pend0.size() > 0);
            if (vld[0]) begin we_a[0] = pend0[0].we; addr_a[0] = pend0[0].addr; wdata_a[0] = pend0[0].data; end
            vld[1] = (pend1.size() > 0);
            if (vld[1]) begin we_a[1] = pend1[0].we; addr_a[1] = pend1[0].addr; wdata_a[1] = pend1[0].data; end
        end
    end

    // Monitor: model the expected behaviour for this cycle and compare.
    always @(negedge clk) begin
        logic [1:0] rdy;
        logic [1:0] rv;
        logic [1:0] exp_rdy;
        int win;
        exp_t e;
        cyc++;
        rdy = {req1_ready, req0_ready};
        rv  = {req1_rvalid, req0_rvalid};
        if (rst) begin
            chk("rst_ready", rdy, 2'b00);
            chk("rst_rvalid", rv, 2'b00);
            chk("rst_rf_we", rf_we, 1'b0);
            sb.delete();
            m_last = 1;
            m_next_ok = cyc + 1;
            m_acc_cyc = -1;
            acc = 2'b00;
        end else begin
            if (m_acc_cyc == cyc) begin
                chk("rf_we", rf_we, m_acc.we);
                chk("rf_addr", rf_addr, m_acc.addr);
                if (m_acc.we) begin
                    chk("rf_wdata", rf_wdata, m_acc.data);
                    m_mem[m_acc.addr] = m_acc.data;
                end
            end else begin
                chk("rf_we_idle", rf_we, 1'b0);
                chk("rf_addr_idle", rf_addr, 4'h0);
            end

            exp_rdy = 2'b00;
            if (cyc >= m_next_ok && vld != 2'b00) begin
                win = (vld == 2'b11) ? (1 - m_last) : (vld[1] ? 1 : 0);
                exp_rdy[win] = 1'b1;
                m_acc.we   = we_a[win];
                m_acc.addr = addr_a[win];
                m_acc.data = wdata_a[win];
                e.id   = win;
                e.data = we_a[win] ? wdata_a[win] : m_mem[addr_a[win]];
                e.due  = cyc + 2;
                sb.push_back(e);
                m_acc_cyc = cyc + 1;
                m_next_ok = cyc + 3;
                m_last = win;
            end
            chk("ready", rdy, exp_rdy);
            acc = acc | rdy;

            if (rv != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("rvalid_unexpected", rv, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("rvalid_id", rv, (e.id == 1) ? 2'b10 : 2'b01);
                    chk("rdata", (e.id == 1) ? req1_rdata : req0_rdata, e.data);
                    chk("latency", cyc, e.due);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("rvalid_missing", 1'b0, 1'b1);
                void'(sb.pop_front());
            end
        end
    end

    function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_t o;
        o.we = we; o.addr = a; o.data = d;
        return o;
    endfunction

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pend0.size() == 0 && pend1.size() == 0 && sb.size() == 0 && acc == 2'b00 && vld == 2'b00) break;
        end
        if (i >= 400) chk("idle_timeout", 1'b0, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        int i;
        for (int k = 0; k < 16; k++) begin rf_mem[k] = '0; m_mem[k] = '0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Write then read back through requester 0.
        pend0.push_back(mk(1'b1, 4'd3, 8'hA5));
        pend0.push_back(mk(1'b0, 4'd3, 8'h00));
        wait_idle();

        // Tie right after reset: requester 0 must win first.
        pend0.push_back(mk(1'b1, 4'd1, 8'h11));
        pend0.push_back(mk(1'b1, 4'd2, 8'h22));
        wait_idle();
        pulse_rst();
        pend0.push_back(mk(1'b0, 4'd1, 8'h00));
        pend1.push_back(mk(1'b0, 4'd2, 8'h00));
        wait_idle();

        // Sustained contention: alternate grants.
        pend0.push_back(mk(1'b0, 4'd1, 8'h00));
        pend0.push_back(mk(1'b1, 4'd9, 8'h99));
        pend1.push_back(mk(1'b0, 4'd2, 8'h00));
        pend1.push_back(mk(1'b1, 4'd10, 8'hAA));
        wait_idle();

        // Lone requester back-to-back.
        pend1.push_back(mk(1'b1, 4'd7, 8'h01));
        pend1.push_back(mk(1'b1, 4'd7, 8'h02));
        pend1.push_back(mk(1'b1, 4'd7, 8'h03));
        pend1.push_back(mk(1'b0, 4'd7, 8'h00));
        wait_idle();

        // Reset landing in the ACCESS cycle aborts the write.
        pend0.push_back(mk(1'b1, 4'd5, 8'h3C));
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) break;
        end
        if (i >= 20) chk("abort_accept_timeout", 1'b0, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_rf_mem5", rf_mem[5], 8'h00);
        pend0.push_back(mk(1'b0, 4'd5, 8'h00));
        wait_idle();

        // Second requester arrives mid-transaction.
        pend0.push_back(mk(1'b0, 4'd3, 8'h00));
        @(posedge clk); #2;
        pend1.push_back(mk(1'b0, 4'd7, 8'h00));
        wait_idle();

        // Random traffic.
        repeat (400) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 2) == 0 && pend0.size() < 3)
                pend0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
            if ($urandom_range(0, 2) == 0 && pend1.size() < 3)
                pend1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
